// File: rtl/avm_rd_pkg.sv
// Shared types and default parameters for the avm_rd_fetch read engine.
package avm_rd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_ADDR_WIDTH   = 32;
    localparam int DEF_MEM_LATENCY  = 2;
    localparam int DEF_FIFO_DEPTH   = 4;
    localparam int DEF_ADDR_STEP    = 8;
    localparam int DEF_IDLE_TIMEOUT = 16;

endpackage

// File: rtl/avm_rd_fifo.sv
// First-word-fall-through output buffer: head is visible while not empty,
// flush drops every entry in one cycle.
module avm_rd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign count_o = count_q;
    // Gate the head so an empty buffer never exposes stale storage.
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge ap_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/avm_rd_fetch.sv
// Sequential read engine: issues credit-limited reads to a fixed-latency
// memory and streams the returned words to the bridge through a FWFT buffer.
module avm_rd_fetch
    import avm_rd_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int ADDR_STEP    = DEF_ADDR_STEP,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [ADDR_WIDTH-1:0] avm_rd_addres,
    input  logic                  avm_rd_ready,
    output logic                  avm_rd_vaild,
    output logic [DATA_WIDTH-1:0] avm_rd_data,
    output logic                  rd_ready,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  busy
);

    localparam int INF_W = $clog2(MEM_LATENCY + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CRD_W = $clog2(MEM_LATENCY + FIFO_DEPTH + 1);
    localparam int IDL_W = $clog2(IDLE_TIMEOUT + 1);

    state_e                  state_q;
    state_e                  state_d;
    logic                    rdy_q;
    logic [ADDR_WIDTH-1:0]   next_addr_q;
    logic [ADDR_WIDTH-1:0]   next_addr_d;
    logic [IDL_W-1:0]        idle_cnt_q;
    logic [IDL_W-1:0]        idle_cnt_d;
    logic [MEM_LATENCY-1:0]  tag_q;
    logic [MEM_LATENCY-1:0]  tag_d;
    logic [INF_W-1:0]        inflight;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_flush;
    logic                    start;
    logic                    idle_expired;
    logic                    issue;

    assign start        = avm_rd_ready & ~rdy_q;
    assign idle_expired = ~avm_rd_ready && (idle_cnt_q == IDL_W'(IDLE_TIMEOUT - 1));

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight = inflight + INF_W'(tag_q[i]);
        end
    end

    // State register
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)          state_d = ACTIVE;
            ACTIVE:  if (idle_expired)   state_d = DRAIN;
            DRAIN:   if (inflight == '0) state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // Outputs come from registered state and counters only; avm_rd_ready
    // never reaches the issue path.
    always_comb begin
        issue       = (state_q == ACTIVE) &&
                      ((CRD_W'(inflight) + CRD_W'(fifo_count)) < CRD_W'(FIFO_DEPTH));
        mem_rd_en   = issue;
        rd_ready    = issue;
        mem_rd_addr = issue ? next_addr_q : '0;
        busy        = (state_q != IDLE);
        fifo_flush  = (state_q == DRAIN) && (inflight == '0);
    end

    always_comb begin
        next_addr_d = next_addr_q;
        idle_cnt_d  = idle_cnt_q;
        if (state_q == IDLE && start) begin
            next_addr_d = avm_rd_addres;
            idle_cnt_d  = '0;
        end else if (state_q == ACTIVE) begin
            if (issue) begin
                next_addr_d = next_addr_q + ADDR_WIDTH'(ADDR_STEP);
            end
            idle_cnt_d = avm_rd_ready ? '0 : idle_cnt_q + IDL_W'(1);
        end
    end

    // Each tag marks a read whose data appears MEM_LATENCY cycles later.
    assign tag_d[0] = issue;
    for (genvar gi = 1; gi < MEM_LATENCY; gi++) begin : g_tag
        assign tag_d[gi] = tag_q[gi-1];
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rdy_q       <= 1'b0;
            next_addr_q <= '0;
            idle_cnt_q  <= '0;
            tag_q       <= '0;
        end else begin
            rdy_q       <= avm_rd_ready;
            next_addr_q <= next_addr_d;
            idle_cnt_q  <= idle_cnt_d;
            tag_q       <= tag_d;
        end
    end

    assign fifo_push    = tag_q[MEM_LATENCY-1];
    assign avm_rd_vaild = ~fifo_empty;
    assign fifo_pop     = avm_rd_vaild & avm_rd_ready;

    avm_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .push_i      (fifo_push),
        .push_data_i (mem_rd_data),
        .pop_i       (fifo_pop),
        .flush_i     (fifo_flush),
        .head_o      (avm_rd_data),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    // The credit check must make this unreachable.
    a_no_overflow: assert property (@(posedge ap_clk) disable iff (ap_rst)
                                    !(fifo_push && fifo_full));

endmodule
